// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// States, result-mux codes and operand constants live here so the top and counter agree.
package muldiv_sequencer_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 5;

  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_WAIT = 2'b01,
    ST_DIV_RUN  = 2'b10,
    ST_DIV_DONE = 2'b11
  } md_state_e;

  // EX result mux select codes
  typedef enum logic [2:0] {
    RES_ALU   = 3'b000,
    RES_QUOT  = 3'b001,
    RES_REM   = 3'b010,
    RES_DATA1 = 3'b011,
    RES_ONES  = 3'b100,
    RES_ZERO  = 3'b101
  } ressel_e;

endpackage

// File: rtl/muldiv_sequencer_step_counter.sv
// Iteration counter for the divider: synchronous clear has priority over enable,
// and tc flags the last iteration so the sequencer can leave DIV_RUN.
module md_step_counter
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int LAST  = DIV_STEPS - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == WIDTH'(LAST));

endmodule

// File: rtl/muldiv_sequencer.sv
// Control sequencer for the M-extension datapath in EX: drives the pipelined multiplier
// and iterative divider, resolves divide special cases in one cycle, and merges stalls.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_ismd,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  input  logic            haz_stall,
  output logic            mul_en,
  output logic            div_load,
  output logic            div_step,
  output logic            div_signed,
  output logic [CNT_W-1:0] div_count,
  output logic [2:0]      ressel,
  output logic            stall_out,
  output logic            bubble_out,
  output logic            md_busy
);

  md_state_e state_q, state_d;
  ressel_e   ressel_c;
  logic [1:0] op_q;
  logic start, is_div, div_by_zero, overflow, md_stall;
  logic cnt_clear, cnt_en, cnt_tc;

  // rst_n gates start so every control stays low while reset is held
  assign start       = rst_n & ex_valid & ex_ismd & ~flush & (state_q == ST_IDLE);
  assign is_div      = ex_funct3[2];
  assign div_by_zero = (data2 == '0);
  assign overflow    = ~ex_funct3[0] & (data1 == INT_MIN) & (data2 == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (div_load) begin
        op_q <= ex_funct3[1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mul_en     = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    div_signed = 1'b0;
    ressel_c   = RES_ALU;
    md_stall   = 1'b0;
    bubble_out = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    if (flush) begin
      state_d   = ST_IDLE;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_clear = 1'b1;
          if (start) begin
            if (!is_div) begin
              mul_en     = 1'b1;
              md_stall   = 1'b1;
              bubble_out = 1'b1;
              state_d    = ST_MUL_WAIT;
            end else if (div_by_zero) begin
              ressel_c = ex_funct3[1] ? RES_DATA1 : RES_ONES;
            end else if (overflow) begin
              ressel_c = ex_funct3[1] ? RES_ZERO : RES_DATA1;
            end else begin
              div_load   = 1'b1;
              div_signed = ~ex_funct3[0];
              md_stall   = 1'b1;
              bubble_out = 1'b1;
              state_d    = ST_DIV_RUN;
            end
          end
        end
        ST_MUL_WAIT: begin
          state_d = ST_IDLE;
        end
        ST_DIV_RUN: begin
          div_step   = 1'b1;
          div_signed = ~op_q[0];
          md_stall   = 1'b1;
          bubble_out = 1'b1;
          cnt_en     = 1'b1;
          if (cnt_tc) begin
            state_d = ST_DIV_DONE;
          end
        end
        ST_DIV_DONE: begin
          div_signed = ~op_q[0];
          ressel_c   = op_q[1] ? RES_REM : RES_QUOT;
          state_d    = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  md_step_counter #(
    .WIDTH(CNT_W),
    .LAST (DIV_STEPS - 1)
  ) u_step_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .enable(cnt_en),
    .count (div_count),
    .tc    (cnt_tc)
  );

  assign ressel    = ressel_c;
  assign stall_out = haz_stall | md_stall;
  assign md_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed bench for muldiv_sequencer against an instruction-level
// timing model: each M op is classified and its per-cycle control trace derived from its latency.
module tb_muldiv_sequencer;

  typedef struct packed {
    logic       mul_en;
    logic       div_load;
    logic       div_step;
    logic       div_signed;
    logic [4:0] cnt;
    logic [2:0] ressel;
    logic       stall;
    logic       bubble;
    logic       busy;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ismd;
  logic [2:0]  ex_funct3;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        flush;
  logic        haz_stall;
  logic        mul_en;
  logic        div_load;
  logic        div_step;
  logic        div_signed;
  logic [4:0]  div_count;
  logic [2:0]  ressel;
  logic        stall_out;
  logic        bubble_out;
  logic        md_busy;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_ismd   (ex_ismd),
    .ex_funct3 (ex_funct3),
    .data1     (data1),
    .data2     (data2),
    .flush     (flush),
    .haz_stall (haz_stall),
    .mul_en    (mul_en),
    .div_load  (div_load),
    .div_step  (div_step),
    .div_signed(div_signed),
    .div_count (div_count),
    .ressel    (ressel),
    .stall_out (stall_out),
    .bubble_out(bubble_out),
    .md_busy   (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Divide special cases: zero divisor, or signed INT_MIN / -1
  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Cycles the instruction occupies EX
  function automatic int op_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (is_special(f3, a, b)) return 1;
    return 34;
  endfunction

  // Expected outputs in cycle t (0 = first cycle the op is in EX) of one instruction
  function automatic obs_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input int t, input logic hz);
    obs_t e;
    bit mul, spec, norm, md;
    e    = '0;
    mul  = !f3[2];
    spec = is_special(f3, a, b);
    norm = f3[2] && !spec;
    md   = (mul && t == 0) || (norm && t <= 32);
    e.busy       = (t > 0);
    e.stall      = md | hz;
    e.bubble     = md;
    e.mul_en     = mul && t == 0;
    e.div_load   = norm && t == 0;
    e.div_step   = norm && t >= 1 && t <= 32;
    e.cnt        = e.div_step ? 5'(t - 1) : 5'd0;
    e.div_signed = norm && !f3[0];
    if (spec) begin
      if (b == 32'd0) e.ressel = f3[1] ? 3'b011 : 3'b100;
      else            e.ressel = f3[1] ? 3'b101 : 3'b011;
    end else if (norm && t == 33) begin
      e.ressel = f3[1] ? 3'b010 : 3'b001;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    return {mul_en, div_load, div_step, div_signed, div_count, ressel, stall_out, bubble_out, md_busy};
  endfunction

  obs_t expct;
  obs_t got;

  task automatic drive(input logic v, input logic m, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic hz);
    ex_valid  = v;
    ex_ismd   = m;
    ex_funct3 = f3;
    data1     = a;
    data2     = b;
    flush     = fl;
    haz_stall = hz;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #3;
    expct = '0;
    expct.stall = 1'b1;
    got = sample();
    checks++;
    if (got !== expct) begin
      errors++;
      $display("[TB] FAIL reset_haz got=%h exp=%h", got, expct);
    end
    haz_stall = 1'b0;
    #1;
    got = sample();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("[TB] FAIL reset_quiet got=%h exp=%h", got, obs_t'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu_directed();
    logic [31:0] a = 32'd100, b = 32'd7;
    for (int t = 0; t < op_latency(3'b101, a, b); t++) begin
      drive(1'b1, 1'b1, 3'b101, a, b, 1'b0, 1'b0);
      @(negedge clk);
      expct = model(3'b101, a, b, t, 1'b0);
      got = sample();
      checks++;
      if (got !== expct) begin
        errors++;
        $display("[TB] FAIL divu_100_7 t=%0d got=%h exp=%h", t, got, expct);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_rem_directed();
    logic [31:0] a = -32'sd7, b = 32'd2;
    logic hz;
    for (int t = 0; t < op_latency(3'b110, a, b); t++) begin
      hz = 1'($urandom_range(0, 1));
      drive(1'b1, 1'b1, 3'b110, a, b, 1'b0, hz);
      @(negedge clk);
      expct = model(3'b110, a, b, t, hz);
      got = sample();
      checks++;
      if (got !== expct) begin
        errors++;
        $display("[TB] FAIL rem_m7_2 t=%0d got=%h exp=%h", t, got, expct);
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    got = sample();
    checks++;
    if (got.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rem_busy_fall got=%b exp=0", got.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_special();
    logic [2:0]  f3s [5] = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b101};
    logic [31:0] as  [5] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < op_latency(f3s[k], as[k], bs[k]); t++) begin
        drive(1'b1, 1'b1, f3s[k], as[k], bs[k], 1'b0, 1'b0);
        @(negedge clk);
        expct = model(f3s[k], as[k], bs[k], t, 1'b0);
        got = sample();
        checks++;
        if (got !== expct) begin
          errors++;
          $display("[TB] FAIL special_%0d t=%0d got=%h exp=%h", k, t, got, expct);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3s [2] = '{3'b000, 3'b001};
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 2; t++) begin
        drive(1'b1, 1'b1, f3s[k], $urandom, $urandom, 1'b0, 1'b0);
        @(negedge clk);
        expct = model(f3s[k], data1, data2, t, 1'b0);
        got = sample();
        checks++;
        if (got !== expct) begin
          errors++;
          $display("[TB] FAIL mul_b2b_%0d t=%0d got=%h exp=%h", k, t, got, expct);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_flush();
    for (int t = 0; t <= 11; t++) begin
      drive(1'b1, 1'b1, 3'b100, 32'd1000, 32'd3, (t == 11), 1'b0);
      @(negedge clk);
      expct = model(3'b100, 32'd1000, 32'd3, t, 1'b0);
      if (t == 11) begin
        expct = '0;
        expct.cnt  = 5'd10;
        expct.busy = 1'b1;
      end
      got = sample();
      checks++;
      if (got !== expct) begin
        errors++;
        $display("[TB] FAIL flush_div t=%0d got=%h exp=%h", t, got, expct);
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    got = sample();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("[TB] FAIL flush_idle got=%h exp=%h", got, obs_t'(0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    for (int t = 0; t < 6; t++) begin
      drive(1'b1, 1'b1, 3'b111, 32'd77, 32'd5, 1'b0, 1'b0);
      @(negedge clk);
      expct = model(3'b111, 32'd77, 32'd5, t, 1'b0);
      got = sample();
      checks++;
      if (got !== expct) begin
        errors++;
        $display("[TB] FAIL areset_pre t=%0d got=%h exp=%h", t, got, expct);
      end
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = sample();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("[TB] FAIL areset_now got=%h exp=%h", got, obs_t'(0));
    end
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        hz, m;
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (n % 4 == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        hz = 1'($urandom_range(0, 1));
        m  = 1'($urandom_range(0, 1));
        drive(1'b0, m, f3, a, b, 1'b0, hz);
        @(negedge clk);
        expct = '0;
        expct.stall = hz;
        got = sample();
        checks++;
        if (got !== expct) begin
          errors++;
          $display("[TB] FAIL rand_gap n=%0d got=%h exp=%h", n, got, expct);
        end
        @(posedge clk);
        #1;
      end
      for (int t = 0; t < op_latency(f3, a, b); t++) begin
        hz = 1'($urandom_range(0, 3) == 0);
        drive(1'b1, 1'b1, f3, a, b, 1'b0, hz);
        @(negedge clk);
        expct = model(f3, a, b, t, hz);
        got = sample();
        checks++;
        if (got !== expct) begin
          errors++;
          $display("[TB] FAIL rand_op n=%0d f3=%b t=%0d got=%h exp=%h", n, f3, t, got, expct);
        end
        @(posedge clk);
        #1;
      end
    end
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_divu_directed();
    test_rem_directed();
    test_special();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
